// File: rtl/stream_tx_pkg.sv
// stream_tx_pkg: shared state encoding and default sizing for the stream transmitter
package stream_tx_pkg;
    localparam int T_DEF     = 16;
    localparam int DEPTH_DEF = 9984;
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
endpackage

// File: rtl/stream_tx_mem_if.sv
// stream_tx_mem_if: load port, launch controls and output stream of the transmitter
interface stream_tx_mem_if import stream_tx_pkg::*; #(
    parameter int T        = T_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LOGDEPTH = $clog2(DEPTH + 1)
);
    logic                  wr_en;
    logic [LOGDEPTH-1:0]   wr_addr;
    logic signed [T-1:0]   wr_data;
    logic                  start;
    logic [LOGDEPTH-1:0]   len;
    logic signed [T-1:0]   m_data_out_x;
    logic                  m_valid_x;
    logic                  m_ready_x;
    logic                  busy;
    logic                  done;
    logic [LOGDEPTH-1:0]   tx_cnt;
    modport master (
        input  wr_en, wr_addr, wr_data, start, len, m_ready_x,
        output m_data_out_x, m_valid_x, busy, done, tx_cnt
    );
    modport slave (
        output wr_en, wr_addr, wr_data, start, len, m_ready_x,
        input  m_data_out_x, m_valid_x, busy, done, tx_cnt
    );
endinterface

// File: rtl/tx_fifo2.sv
// tx_fifo2: two-entry output FIFO with occupancy and synchronous active-low clear
module tx_fifo2 #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                i_clr_n,
    input  logic                i_push,
    input  logic signed [W-1:0] i_data,
    input  logic                i_ready,
    output logic                o_valid,
    output logic signed [W-1:0] o_data,
    output logic [1:0]          o_occ
);
    logic signed [W-1:0] r_mem [2];
    logic                r_rd;
    logic                r_wr;
    logic [1:0]          r_occ;
    logic                w_pop;

    assign o_valid = r_occ != 2'd0;
    assign o_data  = r_mem[r_rd];
    assign o_occ   = r_occ;
    assign w_pop   = o_valid && i_ready;

    // Storage is not cleared; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    // Pointer and occupancy bookkeeping; the producer never pushes into a full FIFO.
    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_occ <= 2'd0;
        end else begin
            if (i_push) r_wr <= ~r_wr;
            if (w_pop) r_rd <= ~r_rd;
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/stream_tx_mem.sv
// stream_tx_mem: RAM-backed transmitter replaying words 0..len-1 over valid/ready
module stream_tx_mem import stream_tx_pkg::*; #(
    parameter int T        = T_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int LOGDEPTH = $clog2(DEPTH + 1)
) (
    input logic             clk,
    input logic             reset,
    stream_tx_mem_if.master bus
);
    state_t              r_state;
    state_t              w_state_nx;
    logic signed [T-1:0] r_mem [DEPTH];
    logic signed [T-1:0] r_rd_data;
    logic signed [T-1:0] w_head;
    logic [LOGDEPTH-1:0] r_len;
    logic [LOGDEPTH-1:0] r_rd_ptr;
    logic [LOGDEPTH-1:0] r_tx_cnt;
    logic [LOGDEPTH-1:0] w_len_sat;
    logic                r_inflight;
    logic [1:0]          w_occ;
    logic                w_fifo_valid;
    logic                w_launch;
    logic                w_issue;
    logic                w_pop;
    logic                w_last;
    logic                w_wr;
    logic                w_clr_n;

    assign w_launch  = bus.start && r_state != STREAM;
    assign w_len_sat = bus.len > LOGDEPTH'(DEPTH) ? LOGDEPTH'(DEPTH) : bus.len;
    assign w_wr      = bus.wr_en && r_state != STREAM && bus.wr_addr < LOGDEPTH'(DEPTH);
    assign w_pop     = bus.m_valid_x && bus.m_ready_x;
    assign w_last    = w_pop && r_tx_cnt == r_len - LOGDEPTH'(1);
    // Words in the FIFO plus the one in the RAM pipeline must leave room after this cycle's pop.
    assign w_issue   = r_state == STREAM && r_rd_ptr < r_len
                       && 3'(w_occ) + 3'(r_inflight) <= 3'd1 + 3'(w_pop);
    assign w_clr_n   = reset && !w_launch;

    assign bus.m_valid_x    = w_fifo_valid && r_state == STREAM;
    assign bus.m_data_out_x = bus.m_valid_x ? w_head : '0;
    assign bus.busy         = r_state == STREAM;
    assign bus.done         = r_state == DONE;
    assign bus.tx_cnt       = r_tx_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else r_state <= w_state_nx;
    end

    // Next state: launch from IDLE/DONE, finish on the final handshake; len==0 skips streaming.
    always_comb begin
        w_state_nx = r_state;
        if (r_state == STREAM) w_state_nx = w_last ? DONE : STREAM;
        else if (bus.start) w_state_nx = bus.len == '0 ? DONE : STREAM;
    end

    // Load-port writes and the registered read; a write on the launch edge lands before the first read.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[bus.wr_addr] <= bus.wr_data;
        if (w_issue) r_rd_data <= r_mem[r_rd_ptr];
    end

    // Run bookkeeping: length latch, read pointer, handshake count and the in-flight read flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len      <= '0;
            r_rd_ptr   <= '0;
            r_tx_cnt   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_launch) begin
                r_len    <= w_len_sat;
                r_rd_ptr <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_issue) r_rd_ptr <= r_rd_ptr + LOGDEPTH'(1);
                if (w_pop) r_tx_cnt <= r_tx_cnt + LOGDEPTH'(1);
            end
        end
    end

    tx_fifo2 #(.W(T)) u_fifo (
        .clk     (clk),
        .i_clr_n (w_clr_n),
        .i_push  (r_inflight),
        .i_data  (r_rd_data),
        .i_ready (bus.m_ready_x && r_state == STREAM),
        .o_valid (w_fifo_valid),
        .o_data  (w_head),
        .o_occ   (w_occ)
    );
endmodule
